// File: rtl/note_seq_pkg.sv
// Shared state type, score-word field layout and note decoding for the note sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  localparam int DUR_MSB  = 15;
  localparam int DUR_LSB  = 8;
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 0;

  localparam logic [3:0] SEMITONE_MAX = 4'd12;
  localparam logic [2:0] OCTAVE_MAX   = 3'd4;

  // Semitone 0 is a rest; codes above SEMITONE_MAX are silent but still timed.
  function automatic logic isSounding(input logic [7:0] code);
    return (code[3:0] != 4'd0) && (code[3:0] <= SEMITONE_MAX);
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Score-word FIFO with synchronous flush; writes while full are dropped and flagged as a sticky overflow.
module note_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [LW-1:0]    level_q;
  logic             overflow_q;
  logic             doPush, doPop;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign rd_data_o  = mem_q[rdPtr_q];

  // The full check uses the registered level, so a pop in the same cycle cannot make room.
  assign doPush = wr_en_i && !full_o && !flush_i;
  assign doPop  = rd_en_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (wr_en_i && full_o) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Score playback engine driving the synthesizer note interface from a FIFO of packed score words.
// Build option NOTE_SEQ_GAP_EN inserts a GAP_TICKS silence after every word; without it words play legato.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [15:0]            wr_data_i,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   pause_i,
  input  logic [1:0]             volume_i,
  output logic [7:0]             note_o,
  output logic                   playing_o,
  output logic [1:0]             volume_o,
  output logic                   busy_o,
  output logic                   note_done_o,
  output logic                   fifo_full_o,
  output logic                   fifo_empty_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   overflow_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_DIV - 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TICK_DIV < 2) || (GAP_TICKS < 1)) begin : g_bad_param
    $error("note_sequencer: illegal parameter combination");
  end

  seq_state_e    state_q;
  logic [TW-1:0] tickCnt_q;
  logic [7:0]    durCnt_q;
  logic [7:0]    note_q;
  logic [1:0]    volume_q;
  logic          sound_q;

  logic [15:0]   headWord;
  logic [7:0]    headDur, headNote;
  logic          lastCycle, playEnd, advance, startLoad, nextLoad, pop;

  note_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .flush_i    (stop_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .rd_en_i    (pop),
    .rd_data_o  (headWord),
    .full_o     (fifo_full_o),
    .empty_o    (fifo_empty_o),
    .level_o    (fifo_level_o),
    .overflow_o (overflow_o)
  );

  assign headDur  = headWord[DUR_MSB:DUR_LSB];
  assign headNote = headWord[NOTE_MSB:NOTE_LSB];

  // Both counters count down and freeze while paused; the last cycle is tick 0 of the final tick.
  assign lastCycle = (tickCnt_q == '0) && (durCnt_q == 8'd1) && !pause_i;
  assign playEnd   = (state_q == PLAY) && lastCycle;
`ifdef NOTE_SEQ_GAP_EN
  localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS);
  assign advance   = (state_q == GAP) && lastCycle;
`else
  assign advance   = playEnd;
`endif
  assign startLoad = (state_q == IDLE) && start_i && !fifo_empty_o;
  assign nextLoad  = advance && !fifo_empty_o;
  assign pop       = !stop_i && (startLoad || nextLoad);

  assign note_o      = note_q;
  assign volume_o    = volume_q;
  assign playing_o   = sound_q && !pause_i;
  assign busy_o      = (state_q != IDLE);
  assign note_done_o = playEnd;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      durCnt_q  <= '0;
      note_q    <= '0;
      volume_q  <= '0;
      sound_q   <= 1'b0;
    end else if (stop_i) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      durCnt_q  <= '0;
      note_q    <= '0;
      sound_q   <= 1'b0;
    end else if (pop) begin
      if (headDur == 8'd0) begin
        state_q <= IDLE;
        note_q  <= '0;
        sound_q <= 1'b0;
      end else begin
        state_q   <= PLAY;
        tickCnt_q <= TICK_RELOAD;
        durCnt_q  <= headDur;
        note_q    <= headNote;
        volume_q  <= volume_i;
        sound_q   <= isSounding(headNote);
      end
    end else if (playEnd) begin
`ifdef NOTE_SEQ_GAP_EN
      state_q   <= GAP;
      tickCnt_q <= TICK_RELOAD;
      durCnt_q  <= GAP_LOAD;
      sound_q   <= 1'b0;
`else
      state_q   <= IDLE;
      note_q    <= '0;
      sound_q   <= 1'b0;
`endif
    end else if (advance) begin
      state_q <= IDLE;
      note_q  <= '0;
      sound_q <= 1'b0;
    end else if ((state_q != IDLE) && !pause_i) begin
      if (tickCnt_q == '0) begin
        tickCnt_q <= TICK_RELOAD;
        durCnt_q  <= durCnt_q - 8'd1;
      end else begin
        tickCnt_q <= tickCnt_q - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: expected note segments and busy periods go into queues when
// stimulus is driven and are popped by a monitor as the DUT completes them.
module tb_note_sequencer;

  localparam int DEPTH     = 16;
  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;
`ifdef NOTE_SEQ_GAP_EN
  localparam int GAP_CLKS = GAP_TICKS * TICK_DIV;
`else
  localparam int GAP_CLKS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wrEn = 1'b0;
  logic [15:0] wrData = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  volumeIn = '0;
  logic [7:0]  note;
  logic        playing;
  logic [1:0]  volume;
  logic        busy;
  logic        noteDone;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [4:0]  fifoLevel;
  logic        overflow;

  typedef struct {
    logic [7:0] note;
    int         play;
    int         total;
  } seg_t;

  seg_t expQ[$];
  int   expBusyQ[$];
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   wordCycles = 0;
  int   playCycles = 0;
  int   busyRun = 0;
  int   gapLeft = 0;
  int   gapPlay = 0;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr_en_i      (wrEn),
    .wr_data_i    (wrData),
    .start_i      (start),
    .stop_i       (stop),
    .pause_i      (pause),
    .volume_i     (volumeIn),
    .note_o       (note),
    .playing_o    (playing),
    .volume_o     (volume),
    .busy_o       (busy),
    .note_done_o  (noteDone),
    .fifo_full_o  (fifoFull),
    .fifo_empty_o (fifoEmpty),
    .fifo_level_o (fifoLevel),
    .overflow_o   (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    wrEn   = 1'b1;
    wrData = word;
    tick();
    wrEn   = 1'b0;
  endtask

  task automatic pulseStart(input logic [1:0] vol);
    volumeIn = vol;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  // Monitor: measures each word from its first cycle to its note_done and each busy period as a whole.
  always @(negedge clk) begin
    if (busy) begin
      busyRun++;
      if (gapLeft > 0) begin
        gapLeft--;
        if (playing) gapPlay++;
      end else begin
        wordCycles++;
        if (playing) playCycles++;
      end
    end
    if (noteDone) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected note_done", 32'd1, 32'd0);
      end else begin
        seg_t e;
        e = expQ.pop_front();
        checkOutput("segment note", {24'd0, note}, {24'd0, e.note});
        checkOutput("segment playing clocks", playCycles, e.play);
        checkOutput("segment length", wordCycles, e.total);
      end
      wordCycles = 0;
      playCycles = 0;
      gapLeft    = GAP_CLKS;
    end
    if (!busy && busyRun > 0) begin
      if (expBusyQ.size() == 0) checkOutput("unexpected busy period", busyRun, 0);
      else checkOutput("busy length", busyRun, expBusyQ.pop_front());
      checkOutput("playing during gap", gapPlay, 0);
      busyRun    = 0;
      wordCycles = 0;
      playCycles = 0;
      gapLeft    = 0;
      gapPlay    = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneBefore;

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset note", {24'd0, note}, 32'd0);
    checkOutput("reset playing", {31'd0, playing}, 32'd0);
    checkOutput("reset volume", {30'd0, volume}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset note_done", {31'd0, noteDone}, 32'd0);
    checkOutput("reset fifo_empty", {31'd0, fifoEmpty}, 32'd1);
    checkOutput("reset fifo_full", {31'd0, fifoFull}, 32'd0);
    checkOutput("reset fifo_level", {27'd0, fifoLevel}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);

    // start with an empty FIFO is ignored
    pulseStart(2'd3);
    @(negedge clk);
    checkOutput("start on empty busy", {31'd0, busy}, 32'd0);

    // Sounding note of 3 ticks followed by an end marker
    $display("[TB] note then end marker");
    applyStimulus(16'h0321);
    applyStimulus(16'h0000);
    @(negedge clk);
    checkOutput("level after two pushes", {27'd0, fifoLevel}, 32'd2);
    expQ.push_back('{8'h21, 12, 12});
    expBusyQ.push_back(12 + GAP_CLKS);
    doneBefore = doneCount;
    pulseStart(2'd2);
    @(negedge clk);
    checkOutput("first note code", {24'd0, note}, 32'h21);
    checkOutput("first note playing", {31'd0, playing}, 32'd1);
    checkOutput("first note volume", {30'd0, volume}, 32'd2);
    checkOutput("first note busy", {31'd0, busy}, 32'd1);
    checkOutput("level after pop", {27'd0, fifoLevel}, 32'd1);
    waitIdle(200);
    checkOutput("note_done pulses t1", doneCount - doneBefore, 32'd1);
    checkOutput("note after end marker", {24'd0, note}, 32'd0);
    checkOutput("fifo empty after t1", {31'd0, fifoEmpty}, 32'd1);

    // Rest word: silent but timed
    $display("[TB] rest word");
    applyStimulus(16'h0210);
    expQ.push_back('{8'h10, 0, 8});
    expBusyQ.push_back(8 + GAP_CLKS);
    doneBefore = doneCount;
    pulseStart(2'd1);
    waitIdle(200);
    checkOutput("note_done pulses rest", doneCount - doneBefore, 32'd1);

    // Pause for 7 clocks in the middle of a 10-tick note
    $display("[TB] pause mid-note");
    applyStimulus(16'h0A31);
    expQ.push_back('{8'h31, 40, 47});
    expBusyQ.push_back(47 + GAP_CLKS);
    pulseStart(2'd1);
    @(negedge clk);
    checkOutput("pause test volume", {30'd0, volume}, 32'd1);
    repeat (9) tick();
    pause = 1'b1;
    repeat (7) tick();
    pause = 1'b0;
    waitIdle(300);

    // Two words back to back
    $display("[TB] consecutive words");
    applyStimulus(16'h0111);
    applyStimulus(16'h0112);
    expQ.push_back('{8'h11, 4, 4});
    expQ.push_back('{8'h12, 4, 4});
    expBusyQ.push_back(8 + 2 * GAP_CLKS);
    pulseStart(2'd0);
    waitIdle(200);

    // Fill past capacity, then stop with a simultaneous write
    $display("[TB] overflow and flush");
    for (int i = 0; i < 17; i++) applyStimulus(16'h0100 | 16'(i + 1));
    @(negedge clk);
    checkOutput("full flag", {31'd0, fifoFull}, 32'd1);
    checkOutput("full level", {27'd0, fifoLevel}, 32'd16);
    checkOutput("overflow set", {31'd0, overflow}, 32'd1);
    stop   = 1'b1;
    wrEn   = 1'b1;
    wrData = 16'h0111;
    tick();
    stop   = 1'b0;
    wrEn   = 1'b0;
    @(negedge clk);
    checkOutput("level after stop", {27'd0, fifoLevel}, 32'd0);
    checkOutput("overflow cleared", {31'd0, overflow}, 32'd0);
    checkOutput("empty after stop", {31'd0, fifoEmpty}, 32'd1);

    // Stop at the 9th clock of a 5-tick note
    $display("[TB] stop mid-note");
    applyStimulus(16'h0521);
    applyStimulus(16'h0111);
    expBusyQ.push_back(9);
    doneBefore = doneCount;
    pulseStart(2'd2);
    repeat (8) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    checkOutput("stop playing", {31'd0, playing}, 32'd0);
    checkOutput("stop busy", {31'd0, busy}, 32'd0);
    checkOutput("stop note", {24'd0, note}, 32'd0);
    checkOutput("stop level", {27'd0, fifoLevel}, 32'd0);
    repeat (30) @(negedge clk);
    checkOutput("no note_done on stop", doneCount - doneBefore, 32'd0);

    // Reset in the middle of a note
    $display("[TB] reset mid-note");
    applyStimulus(16'h0521);
    applyStimulus(16'h0122);
    expBusyQ.push_back(6);
    pulseStart(2'd3);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset mid busy", {31'd0, busy}, 32'd0);
    checkOutput("reset mid playing", {31'd0, playing}, 32'd0);
    checkOutput("reset mid volume", {30'd0, volume}, 32'd0);
    checkOutput("reset mid empty", {31'd0, fifoEmpty}, 32'd1);
    @(negedge clk);

    checkOutput("segments outstanding", expQ.size(), 32'd0);
    checkOutput("busy periods outstanding", expBusyQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
